// File: rtl/fifo_burst_pkg.sv
// -----------------------------------------------------------------------------
// fifo_burst_pkg
// Shared types and constants for the FIFO burst reader and its skid buffer.
//   state_t      : burst reader FSM states
//   skid_entry_t : one skid-buffer slot at the default data width
//   SKID_DEPTH   : number of skid slots (covers the FIFO's 1-cycle read latency)
// -----------------------------------------------------------------------------
package fifo_burst_pkg;

    localparam int unsigned SKID_DEPTH     = 2;
    localparam int unsigned SKID_DATA_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        ZERO,
        BURST,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                      valid;
        logic                      last;
        logic [SKID_DATA_BITS-1:0] data;
    } skid_entry_t;

endpackage

// File: rtl/fifo_skid_buf_2.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf_2
// Two-entry, strictly ordered buffer. Entry 0 is the head. Push and pop may
// occur in the same cycle. The caller must never push while full unless it
// also pops in that cycle; that case is not guarded here.
// Ports:
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_push, i_push_last/data  : write a new entry at the tail
//   i_pop                     : drop the head (ignored when empty)
//   o_occ                     : number of valid entries (0..2)
//   o_head_valid/last/data    : head entry, straight from registers
// -----------------------------------------------------------------------------
module fifo_skid_buf_2
    import fifo_burst_pkg::*;
#(
    parameter int unsigned DATA_BITS = SKID_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_push,
    input  logic                 i_push_last,
    input  logic [DATA_BITS-1:0] i_push_data,
    input  logic                 i_pop,
    output logic [1:0]           o_occ,
    output logic                 o_head_valid,
    output logic                 o_head_last,
    output logic [DATA_BITS-1:0] o_head_data
);

    typedef struct packed {
        logic                 valid;
        logic                 last;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    entry_t r_e0;
    entry_t r_e1;
    entry_t w_e0_d;
    entry_t w_e1_d;
    entry_t w_new;
    logic   w_pop;

    always_comb begin
        w_e0_d = r_e0;
        w_e1_d = r_e1;
        w_pop  = i_pop && r_e0.valid;
        w_new  = '{valid: 1'b1, last: i_push_last, data: i_push_data};

        // Shift first, then place the new entry in the first free slot, so a
        // simultaneous push/pop keeps strict ordering at any occupancy.
        if (w_pop) begin
            w_e0_d       = r_e1;
            w_e1_d.valid = 1'b0;
        end
        if (i_push) begin
            if (!w_e0_d.valid) begin
                w_e0_d = w_new;
            end else begin
                w_e1_d = w_new;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_e0 <= '0;
            r_e1 <= '0;
        end else begin
            r_e0 <= w_e0_d;
            r_e1 <= w_e1_d;
        end
    end

    assign o_occ        = {1'b0, r_e0.valid} + {1'b0, r_e1.valid};
    assign o_head_valid = r_e0.valid;
    assign o_head_last  = r_e0.last;
    assign o_head_data  = r_e0.data;

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Accepts a burst command, pops exactly cmd_len words from a FIFO read port
// (1-cycle read latency) and streams them out on valid/ready with a last flag.
// Ports:
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready/i_cmd_len : burst command handshake and length
//   i_fifo_empty, o_fifo_rd_en, i_fifo_rd_data : FIFO read interface
//   o_out_valid/i_out_ready/o_out_data/o_out_last : output stream
//   o_busy                         : high whenever not idle
//   o_done                         : one-cycle pulse at burst completion
// -----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 11,
    parameter int unsigned FIFO_LENGTH = 16,
    parameter int unsigned LEN_BITS    = $clog2(FIFO_LENGTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [LEN_BITS-1:0]  i_cmd_len,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    input  logic [DATA_BITS-1:0] i_fifo_rd_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [DATA_BITS-1:0] o_out_data,
    output logic                 o_out_last,
    output logic                 o_busy,
    output logic                 o_done
);

    state_t                r_state;
    state_t                w_state_d;
    logic [LEN_BITS-1:0]   r_len;
    logic [LEN_BITS-1:0]   r_issued;     // pops issued in this burst
    logic [LEN_BITS-1:0]   r_remaining;  // words still to be captured
    logic                  r_inflight;   // pop issued last cycle, data arrives now

    logic [LEN_BITS-1:0]   w_cmd_len;
    logic                  w_rd_en;
    logic                  w_pop_out;
    logic                  w_last_hs;
    logic                  w_credit_ok;
    logic [1:0]            w_occ;
    logic                  w_head_valid;
    logic                  w_head_last;
    logic [DATA_BITS-1:0]  w_head_data;

    // Over-length commands are illegal; clamp rather than over-read the FIFO.
    assign w_cmd_len = (i_cmd_len > LEN_BITS'(FIFO_LENGTH)) ? LEN_BITS'(FIFO_LENGTH)
                                                            : i_cmd_len;

    assign w_pop_out = w_head_valid && i_out_ready;
    assign w_last_hs = w_pop_out && o_out_last;

    // Credit: stored + in-flight words, after this cycle's output pop, must
    // leave room for one more, so the 2-entry skid buffer can never overflow.
    assign w_credit_ok = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop_out});

    assign w_rd_en = (r_state == BURST) && (r_issued < r_len) && !i_fifo_empty && w_credit_ok;

    always_comb begin
        w_state_d   = r_state;
        o_cmd_ready = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_state_d = (w_cmd_len == '0) ? ZERO : BURST;
                end
            end
            ZERO: begin
                o_done    = 1'b1;
                w_state_d = IDLE;
            end
            BURST: begin
                if (w_rd_en && ((r_issued + LEN_BITS'(1)) == r_len)) begin
                    w_state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_hs) begin
                    o_done    = 1'b1;
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_inflight <= w_rd_en;
            if (o_cmd_ready && i_cmd_valid) begin
                r_len       <= w_cmd_len;
                r_issued    <= '0;
                r_remaining <= w_cmd_len;
            end else begin
                if (w_rd_en) begin
                    r_issued <= r_issued + LEN_BITS'(1);
                end
                if (r_inflight && (r_remaining != '0)) begin
                    r_remaining <= r_remaining - LEN_BITS'(1);
                end
            end
        end
    end

    fifo_skid_buf_2 #(
        .DATA_BITS (DATA_BITS)
    ) u_skid (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push       (r_inflight),
        // The word captured while exactly one remains is beat len-1.
        .i_push_last  (r_remaining == LEN_BITS'(1)),
        .i_push_data  (i_fifo_rd_data),
        .i_pop        (i_out_ready),
        .o_occ        (w_occ),
        .o_head_valid (w_head_valid),
        .o_head_last  (w_head_last),
        .o_head_data  (w_head_data)
    );

    assign o_fifo_rd_en = w_rd_en;
    assign o_out_valid  = w_head_valid;
    assign o_out_data   = w_head_data;
    assign o_out_last   = w_head_valid && w_head_last;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Directed bench for fifo_burst_reader with a behavioural FIFO read port
// (data valid the cycle after a pop).
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DW = 11;
    localparam int LW = 5;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    fifo_burst_reader #(
        .DATA_BITS   (DW),
        .FIFO_LENGTH (16),
        .LEN_BITS    (LW)
    ) u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_len      (cmd_len),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_rd_en   (fifo_rd_en),
        .i_fifo_rd_data (fifo_rd_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_data     (out_data),
        .o_out_last     (out_last),
        .o_busy         (busy),
        .o_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO read side
    int fq[$];
    int underflow = 0;

    always @(posedge clk) begin
        if (reset) begin
            fifo_rd_data <= '0;
        end else if (fifo_rd_en) begin
            if (fq.size() == 0) underflow++;
            else fifo_rd_data <= DW'(fq.pop_front());
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Per-test observation state
    int beats[$];
    int cyc_n, n_rd, n_deliv, n_done, n_acc, n_last, n_stall;
    int first_rd, first_vld, first_deliv, last_deliv, done_cyc, acc_cyc, last_pos;
    int rd_empty_err, stall_err, max_out, stall_data;
    int refill_cyc, refill_base;
    logic stall_pend;
    logic [4:0] ready_pat;

    task automatic clear_beats();
        beats.delete();
        n_last   = 0;
        last_pos = -1;
    endtask

    task automatic clear_stats();
        clear_beats();
        cyc_n = 0; n_rd = 0; n_deliv = 0; n_done = 0; n_acc = 0; n_stall = 0;
        first_rd = -1; first_vld = -1; first_deliv = -1; last_deliv = -1;
        done_cyc = -1; acc_cyc = -1;
        rd_empty_err = 0; stall_err = 0; max_out = 0; stall_data = 0;
        refill_cyc = -1; refill_base = 0;
        stall_pend = 1'b0;
    endtask

    task automatic fifo_push(input int v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    // Observe one cycle (inputs already set), then advance past the next edge.
    task automatic run_cycle();
        if (refill_cyc == cyc_n) begin
            for (int i = 0; i < 5; i++) fifo_push(refill_base + i);
        end
        out_ready = ready_pat[cyc_n % 5];
        #1;
        if (n_rd - n_deliv > max_out) max_out = n_rd - n_deliv;
        if (fifo_rd_en) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc_n;
            if (fifo_empty) rd_empty_err++;
        end
        if (out_valid && first_vld < 0) first_vld = cyc_n;
        if (stall_pend && (!out_valid || int'(out_data) != stall_data)) stall_err++;
        stall_pend = out_valid && !out_ready;
        stall_data = int'(out_data);
        if (stall_pend) n_stall++;
        if (out_valid && out_ready) begin
            if (out_last) begin
                n_last++;
                last_pos = beats.size();
            end
            beats.push_back(int'(out_data));
            n_deliv++;
            if (first_deliv < 0) first_deliv = cyc_n;
            last_deliv = cyc_n;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc_n;
        end
        if (cmd_valid && cmd_ready) begin
            n_acc++;
            acc_cyc = cyc_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic start_cmd(input int len);
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        run_cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            run_cycle();
            k++;
        end
        check({tag, "_done_seen"}, int'(n_done >= target), 1);
    endtask

    task automatic check_burst(input string tag, input int base, input int n);
        check({tag, "_count"}, beats.size(), n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, (i < beats.size()) ? beats[i] : -1, base + i);
        end
        check({tag, "_last_count"}, n_last, 1);
        check({tag, "_last_pos"}, last_pos, n - 1);
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        fifo_empty = 1'b1;
        out_ready  = 1'b1;
        ready_pat  = 5'b11111;
        clear_stats();
        run_cycle();
        run_cycle();
        reset = 1'b0;
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_fifo_rd_en", int'(fifo_rd_en), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // 1: ten words, no backpressure
        clear_stats();
        for (int i = 0; i < 10; i++) fifo_push(i);
        start_cmd(10);
        wait_done("t1", 1, 60);
        check_burst("t1", 0, 10);
        check("t1_fill_latency", first_vld - first_rd, 2);
        check("t1_back_to_back", last_deliv - first_deliv, 9);
        check("t1_done_count", n_done, 1);
        check("t1_done_with_last", done_cyc, last_deliv);

        // 2: sixteen words, ready pattern 1,0,1,1,0
        clear_stats();
        for (int i = 0; i < 16; i++) fifo_push(i);
        ready_pat = 5'b01101;
        start_cmd(16);
        wait_done("t2", 1, 120);
        ready_pat = 5'b11111;
        check_burst("t2", 0, 16);
        check("t2_stall_seen", int'(n_stall > 0), 1);
        check("t2_stable_under_stall", stall_err, 0);
        check("t2_outstanding_le2", int'(max_out <= 2), 1);
        check("t2_done_count", n_done, 1);

        // 3: FIFO runs dry mid-burst, refilled later
        clear_stats();
        for (int i = 0; i < 3; i++) fifo_push(20 + i);
        refill_cyc  = 6;
        refill_base = 23;
        start_cmd(8);
        wait_done("t3", 1, 80);
        check_burst("t3", 20, 8);
        check("t3_no_pop_when_empty", rd_empty_err, 0);
        #1;
        check("t3_idle_busy", int'(busy), 0);
        check("t3_idle_cmd_ready", int'(cmd_ready), 1);

        // 4: zero-length command with data available
        clear_stats();
        fifo_push(99);
        start_cmd(0);
        wait_done("t4", 1, 10);
        check("t4_no_pop", n_rd, 0);
        check("t4_no_valid", first_vld, -1);
        check("t4_done_cycle", done_cyc, 1);
        #1;
        check("t4_cmd_ready_after", int'(cmd_ready), 1);
        fq.delete();
        fifo_empty = 1'b1;

        // 5: reset after four beats, then a fresh 2-word burst
        clear_stats();
        for (int i = 0; i < 10; i++) fifo_push(i);
        start_cmd(10);
        for (int k = 0; k < 40 && n_deliv < 4; k++) run_cycle();
        check("t5_four_beats", n_deliv, 4);
        reset = 1'b1;
        fq.delete();
        fifo_empty = 1'b1;
        run_cycle();
        reset = 1'b0;
        #1;
        check("t5_rst_out_valid", int'(out_valid), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_cmd_ready", int'(cmd_ready), 1);
        clear_stats();
        fifo_push(5);
        fifo_push(6);
        start_cmd(2);
        wait_done("t5", 1, 20);
        check_burst("t5", 5, 2);

        // 6: back-to-back commands, len 16 then len 1
        clear_stats();
        for (int i = 0; i < 17; i++) fifo_push(i);
        cmd_valid = 1'b1;
        cmd_len   = LW'(16);
        run_cycle();
        cmd_len = LW'(1);
        wait_done("t6a", 1, 80);
        check_burst("t6a", 0, 16);
        check("t6_single_accept_while_busy", n_acc, 1);
        clear_beats();
        run_cycle();
        cmd_valid = 1'b0;
        check("t6_second_accept_count", n_acc, 2);
        check("t6_second_accept_cycle", acc_cyc, done_cyc + 1);
        wait_done("t6b", 2, 20);
        check_burst("t6b", 16, 1);
        #1;
        check("t6_idle_busy", int'(busy), 0);

        check("fifo_underflow", underflow, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
